// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: instruction word store with a boot-load port and a
// ready/valid fetch port that returns each response one cycle after acceptance.
//
// Optional feature macro: INSTR_MEM_PARITY_EN
//   defined   -> each stored word carries an even-parity bit, and a mismatch
//                on fetch returns error 11.
//   undefined -> plain DWIDTH-wide store, and error 11 never occurs.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   load_valid/data   boot image word, written at the internal load pointer
//   load_last         marks the final word of the image (qualifies load_valid)
//   load_ready        high while in LOAD
//   load_ovf          sticky; a load was attempted past MEMDEPTH words
//   running           high while in RUN
//   req_valid/addr    fetch request (byte address)
//   req_ready         request accepted when req_valid && req_ready
//   flush             drops the in-flight and held response
//   resp_valid/ready  response handshake; the response is held until resp_ready
//   resp_instr        fetched word (0 on error)
//   resp_err          00 ok, 01 misaligned, 10 out of range, 11 parity
module instr_mem_ctrl #(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned MEMDEPTH = 1024,
    parameter int unsigned AWIDTH   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DWIDTH-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_ovf,
    output logic              running,
    input  logic              req_valid,
    input  logic [AWIDTH-1:0] req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DWIDTH-1:0] resp_instr,
    output logic [1:0]        resp_err
);

    localparam int unsigned LWIDTH = $clog2(MEMDEPTH);
    localparam int unsigned PWIDTH = LWIDTH + 1;
`ifdef INSTR_MEM_PARITY_EN
    localparam int unsigned MWIDTH = DWIDTH + 1;
`else
    localparam int unsigned MWIDTH = DWIDTH;
`endif

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PWIDTH-1:0]   ptr_q, ptr_d;
    logic                load_ovf_q, load_ovf_d;
    logic                pend_valid_q, pend_valid_d;
    logic [LWIDTH-1:0]   pend_idx_q, pend_idx_d;
    logic [1:0]          pend_err_q, pend_err_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DWIDTH-1:0]   resp_instr_q, resp_instr_d;
    logic [1:0]          resp_err_q, resp_err_d;

    logic [MWIDTH-1:0]   mem [MEMDEPTH];

    logic                load_in_range;
    logic                mem_we;
    logic [MWIDTH-1:0]   wr_word;
    logic [MWIDTH-1:0]   rd_word;
    logic                par_err;
    logic                advance;
    logic                accept;
    logic                addr_misaligned;
    logic                addr_oor;
    logic [LWIDTH-1:0]   req_idx;

    // Pointer's top bit set means the store is full (ptr == MEMDEPTH).
    assign load_in_range = ~ptr_q[LWIDTH];
    assign mem_we        = (state_q == S_LOAD) && load_valid && load_in_range && !reset;

`ifdef INSTR_MEM_PARITY_EN
    assign wr_word = {^load_data, load_data};
    assign par_err = ^rd_word;
`else
    assign wr_word = load_data;
    assign par_err = 1'b0;
`endif

    // Request and response stages move together whenever the output slot frees up.
    assign advance   = !resp_valid_q || resp_ready;
    assign req_ready = (state_q == S_RUN) && !flush && advance;
    assign accept    = req_valid && req_ready;

    assign req_idx         = req_addr[LWIDTH+1:2];
    assign addr_misaligned = |req_addr[1:0];
    assign addr_oor        = |(req_addr >> (LWIDTH + 2));

    // The index is registered at acceptance, so reads only ever touch mem in RUN.
    assign rd_word = mem[pend_idx_q];

    // Next-state and next-output computation.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        load_ovf_d   = load_ovf_q;
        pend_valid_d = pend_valid_q;
        pend_idx_d   = pend_idx_q;
        pend_err_d   = pend_err_q;
        resp_valid_d = resp_valid_q;
        resp_instr_d = resp_instr_q;
        resp_err_d   = resp_err_q;

        if (state_q == S_LOAD) begin
            if (load_valid) begin
                if (load_in_range) begin
                    ptr_d = ptr_q + PWIDTH'(1);
                end else begin
                    load_ovf_d = 1'b1;
                end
                if (load_last) begin
                    state_d = S_RUN;
                end
            end
        end

        if (flush) begin
            pend_valid_d = 1'b0;
            resp_valid_d = 1'b0;
        end else if (advance) begin
            resp_valid_d = pend_valid_q;
            if (pend_valid_q) begin
                if (pend_err_q != 2'b00) begin
                    resp_err_d   = pend_err_q;
                    resp_instr_d = '0;
                end else if (par_err) begin
                    resp_err_d   = 2'b11;
                    resp_instr_d = '0;
                end else begin
                    resp_err_d   = 2'b00;
                    resp_instr_d = rd_word[DWIDTH-1:0];
                end
            end
            pend_valid_d = accept;
            if (accept) begin
                pend_idx_d = req_idx;
                if (addr_misaligned) begin
                    pend_err_d = 2'b01;
                end else if (addr_oor) begin
                    pend_err_d = 2'b10;
                end else begin
                    pend_err_d = 2'b00;
                end
            end
        end
    end

    // Control and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_LOAD;
            ptr_q        <= '0;
            load_ovf_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= '0;
            pend_err_q   <= 2'b00;
            resp_valid_q <= 1'b0;
            resp_instr_q <= '0;
            resp_err_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            load_ovf_q   <= load_ovf_d;
            pend_valid_q <= pend_valid_d;
            pend_idx_q   <= pend_idx_d;
            pend_err_q   <= pend_err_d;
            resp_valid_q <= resp_valid_d;
            resp_instr_q <= resp_instr_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Word store; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q[LWIDTH-1:0]] <= wr_word;
        end
    end

    assign load_ready = (state_q == S_LOAD);
    assign running    = (state_q == S_RUN);
    assign load_ovf   = load_ovf_q;
    assign resp_valid = resp_valid_q;
    assign resp_instr = resp_instr_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl: a default-size instance and a 4-word instance.
module tb_instr_mem_ctrl;

    logic        clk = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic        reset, load_valid, load_last, flush, req_valid, resp_ready;
    logic [31:0] load_data, req_addr;
    logic        load_ready, load_ovf, running, req_ready, resp_valid;
    logic [31:0] resp_instr;
    logic [1:0]  resp_err;

    logic        s_reset, s_load_valid, s_load_last, s_flush, s_req_valid, s_resp_ready;
    logic [31:0] s_load_data, s_req_addr;
    logic        s_load_ready, s_load_ovf, s_running, s_req_ready, s_resp_valid;
    logic [31:0] s_resp_instr;
    logic [1:0]  s_resp_err;

    always #5 clk = ~clk;

    instr_mem_ctrl #(.DWIDTH(32), .MEMDEPTH(1024), .AWIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .load_ovf(load_ovf), .running(running),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_instr(resp_instr), .resp_err(resp_err)
    );

    instr_mem_ctrl #(.DWIDTH(32), .MEMDEPTH(4), .AWIDTH(32)) u_small (
        .clk(clk), .reset(s_reset),
        .load_valid(s_load_valid), .load_data(s_load_data), .load_last(s_load_last),
        .load_ready(s_load_ready), .load_ovf(s_load_ovf), .running(s_running),
        .req_valid(s_req_valid), .req_addr(s_req_addr), .req_ready(s_req_ready),
        .flush(s_flush), .resp_valid(s_resp_valid), .resp_ready(s_resp_ready),
        .resp_instr(s_resp_instr), .resp_err(s_resp_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        flush = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
        s_reset = 1'b1; s_load_valid = 1'b0; s_load_data = '0; s_load_last = 1'b0;
        s_flush = 1'b0; s_req_valid = 1'b0; s_req_addr = '0; s_resp_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        s_reset = 1'b0;
        step();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b exp 1", load_ready); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running); end
        checks++; if (load_ovf !== 1'b0) begin errors++; $display("FAIL reset_load_ovf got %b exp 0", load_ovf); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++; if (resp_instr !== 32'h0 || resp_err !== 2'b00) begin errors++; $display("FAIL reset_resp got %h/%b exp 0/00", resp_instr, resp_err); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    endtask

    task automatic test_load();
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = 32'(32'h11 * (i + 1));
            load_last  = (i == 3);
            step();
            if (i < 3) begin
                checks++; if (running !== 1'b0) begin errors++; $display("FAIL load_early_run word %0d got %b exp 0", i, running); end
            end
        end
        // Load traffic in RUN must be ignored.
        load_data = 32'hDEAD_BEEF;
        load_last = 1'b1;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL load_running got %b exp 1", running); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load_ready_run got %b exp 0", load_ready); end
        checks++; if (load_ovf !== 1'b0) begin errors++; $display("FAIL load_ovf got %b exp 0", load_ovf); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'(4 * i);
            #1;
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_req_ready %0d got %b exp 1", i, req_ready); end
            step();
            if (i > 0) begin
                exp = 32'(32'h11 * i);
                checks++;
                if (resp_valid !== 1'b1 || resp_instr !== exp || resp_err !== 2'b00) begin
                    errors++; $display("FAIL b2b_resp %0d got v%b %h/%b exp v1 %h/00", i - 1, resp_valid, resp_instr, resp_err, exp);
                end
            end
        end
        req_valid = 1'b0;
        step();
        checks++; if (resp_valid !== 1'b1 || resp_instr !== 32'h44 || resp_err !== 2'b00) begin errors++; $display("FAIL b2b_resp 3 got v%b %h/%b exp v1 00000044/00", resp_valid, resp_instr, resp_err); end
        step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", resp_valid); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [5] = '{32'h6, 32'h1000, 32'h1002, 32'hFFFF_FFFC, 32'hC};
        logic [1:0]  errs  [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        logic [31:0] words [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h44};
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_addr  = addrs[i];
            step();
            req_valid = 1'b0;
            step();
            checks++;
            if (resp_valid !== 1'b1 || resp_err !== errs[i] || resp_instr !== words[i]) begin
                errors++; $display("FAIL err_addr %h got v%b %h/%b exp v1 %h/%b", addrs[i], resp_valid, resp_instr, resp_err, words[i], errs[i]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h4;
        step();
        req_valid = 1'b0;
        step();
        req_valid = 1'b1;
        req_addr  = 32'hC;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_instr !== 32'h22 || resp_err !== 2'b00 || req_ready !== 1'b0) begin
                errors++; $display("FAIL hold cycle %0d got v%b %h/%b rdy%b exp v1 00000022/00 rdy0", i, resp_valid, resp_instr, resp_err, req_ready);
            end
            step();
        end
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got %b exp 1", req_ready); end
        step();
        req_valid = 1'b0;
        step();
        checks++; if (resp_valid !== 1'b1 || resp_instr !== 32'h44) begin errors++; $display("FAIL hold_next_resp got v%b %h exp v1 00000044", resp_valid, resp_instr); end
        step();
    endtask

    task automatic test_flush();
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 32'h8;
        step();
        req_valid = 1'b0;
        flush     = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_req_ready got %b exp 0", req_ready); end
        step();
        flush = 1'b0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got %b exp 0", resp_valid); end
        step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_late got %b exp 0", resp_valid); end
        req_valid = 1'b1;
        req_addr  = 32'hC;
        step();
        req_valid = 1'b0;
        step();
        checks++; if (resp_valid !== 1'b1 || resp_instr !== 32'h44) begin errors++; $display("FAIL flush_after got v%b %h exp v1 00000044", resp_valid, resp_instr); end
        step();
        // Flush against a held response, with resp_ready and a request in the same cycle.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h0;
        step();
        req_valid = 1'b0;
        step();
        checks++; if (resp_valid !== 1'b1 || resp_instr !== 32'h11) begin errors++; $display("FAIL flush_held_pre got v%b %h exp v1 00000011", resp_valid, resp_instr); end
        flush      = 1'b1;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 32'h4;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_wins_ready got %b exp 0", req_ready); end
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_held_drop got %b exp 0", resp_valid); end
        step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept got %b exp 0", resp_valid); end
    endtask

`ifdef INSTR_MEM_PARITY_EN
    task automatic test_parity();
        resp_ready = 1'b1;
        dut.mem[1] = dut.mem[1] ^ 33'd1;
        req_valid  = 1'b1;
        req_addr   = 32'h4;
        step();
        req_valid = 1'b0;
        step();
        checks++; if (resp_valid !== 1'b1 || resp_err !== 2'b11 || resp_instr !== 32'h0) begin errors++; $display("FAIL parity got v%b %h/%b exp v1 00000000/11", resp_valid, resp_instr, resp_err); end
        step();
        req_valid = 1'b1;
        req_addr  = 32'h6;
        step();
        req_valid = 1'b0;
        step();
        checks++; if (resp_err !== 2'b01) begin errors++; $display("FAIL parity_rank got %b exp 01", resp_err); end
        step();
    endtask
`endif

    task automatic test_small_overflow();
        logic [31:0] addrs [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        logic [31:0] words [5] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0};
        logic [1:0]  errs  [5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
        for (int i = 0; i < 5; i++) begin
            s_load_valid = 1'b1;
            s_load_data  = 32'(32'hA0 + i);
            s_load_last  = (i == 4);
            if (i == 4) begin
                checks++; if (s_load_ovf !== 1'b0) begin errors++; $display("FAIL small_ovf_early got %b exp 0", s_load_ovf); end
            end
            step();
        end
        s_load_valid = 1'b0;
        s_load_last  = 1'b0;
        checks++; if (s_load_ovf !== 1'b1) begin errors++; $display("FAIL small_ovf got %b exp 1", s_load_ovf); end
        checks++; if (s_running !== 1'b1) begin errors++; $display("FAIL small_running got %b exp 1", s_running); end
        for (int i = 0; i < 5; i++) begin
            s_req_valid = 1'b1;
            s_req_addr  = addrs[i];
            #1;
            checks++; if (s_req_ready !== 1'b1) begin errors++; $display("FAIL small_req_ready %h got %b exp 1", addrs[i], s_req_ready); end
            step();
            s_req_valid = 1'b0;
            step();
            checks++;
            if (s_resp_valid !== 1'b1 || s_resp_instr !== words[i] || s_resp_err !== errs[i]) begin
                errors++; $display("FAIL small_fetch %h got v%b %h/%b exp v1 %h/%b", addrs[i], s_resp_valid, s_resp_instr, s_resp_err, words[i], errs[i]);
            end
            step();
        end
    endtask

    task automatic test_small_reset_midload();
        logic [31:0] addrs [2] = '{32'h0, 32'h4};
        logic [31:0] words [2] = '{32'hC0, 32'hB1};
        s_reset = 1'b1;
        step();
        s_reset = 1'b0;
        checks++; if (s_load_ready !== 1'b1 || s_running !== 1'b0 || s_load_ovf !== 1'b0) begin errors++; $display("FAIL small_reset got rdy%b run%b ovf%b exp 1 0 0", s_load_ready, s_running, s_load_ovf); end
        for (int i = 0; i < 2; i++) begin
            s_load_valid = 1'b1;
            s_load_data  = 32'(32'hB0 + i);
            s_load_last  = 1'b0;
            step();
        end
        // Reset arrives mid-load with a word still offered.
        s_load_data = 32'hEE;
        #2;
        s_reset = 1'b1;
        step();
        s_reset = 1'b0;
        checks++; if (s_load_ready !== 1'b1 || s_running !== 1'b0) begin errors++; $display("FAIL small_midload_reset got rdy%b run%b exp 1 0", s_load_ready, s_running); end
        s_load_data = 32'hC0;
        s_load_last = 1'b1;
        step();
        s_load_valid = 1'b0;
        s_load_last  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_req_valid = 1'b1;
            s_req_addr  = addrs[i];
            step();
            s_req_valid = 1'b0;
            step();
            checks++;
            if (s_resp_valid !== 1'b1 || s_resp_instr !== words[i] || s_resp_err !== 2'b00) begin
                errors++; $display("FAIL small_reload %h got v%b %h/%b exp v1 %h/00", addrs[i], s_resp_valid, s_resp_instr, s_resp_err, words[i]);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_errors();
        test_backpressure();
        test_flush();
`ifdef INSTR_MEM_PARITY_EN
        test_parity();
`endif
        test_small_overflow();
        test_small_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached exp finish before 200000");
        $fatal(1);
    end

endmodule
